pfpu_cvt_arb: RTL and testbench
===============================

PFPU_CVT_ARB -- requirements
Module: pfpu_cvt_arb

Interface
REQ-001 Parameter LATENCY, default 2, meaning converter latency in cycles from cvt_valid to cvt_valid_i; legal range 1..8.
REQ-002 sys_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 sys_rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  4  per-requester conversion request, port k on bit k.
REQ-005 req_a  input  128  per-requester 32-bit signed integer operand, port k on bits [32k+31:32k].
REQ-006 req_ack  output  4  one-hot grant; request k transferred in a cycle where req_valid[k] and req_ack[k] are both 1.
REQ-007 cvt_a  output  32  operand to shared converter, registered.
REQ-008 cvt_valid  output  1  issue strobe to shared converter, registered.
REQ-009 cvt_r  input  32  converter float result.
REQ-010 cvt_valid_i  input  1  converter result strobe.
REQ-011 res  output  32  result bus to requesters, equal to cvt_r.
REQ-012 res_valid  output  4  one-hot result strobe identifying owning requester.
REQ-013 drain  input  1  when 1, no new grants issued.
REQ-014 idle  output  1  1 when nothing granted, issued or in flight.
REQ-015 err  output  1  sticky protocol error flag.

Function
REQ-016 req_ack shall be combinational from req_valid, drain and round-robin pointer; at most one bit set; all zero when drain=1 or req_valid=0.
REQ-017 Arbitration shall be round-robin: search starts at port (ptr+1) mod 4, wraps, first asserted req_valid wins; ptr updates to winner only on a transfer.
REQ-018 A transfer in cycle t shall produce cvt_valid=1 and cvt_a=req_a of winner in cycle t+1; cvt_valid=0 in cycles without prior transfer; cvt_a holds last value when cvt_valid=0.
REQ-019 One transfer per cycle maximum; back-to-back transfers every cycle supported, no bubbles.
REQ-020 Block shall keep a LATENCY-deep tag pipeline (valid bit + 2-bit port id), loaded from the cvt_valid stage and advanced every cycle unconditionally.
REQ-021 Tag emerging at tail aligns with cvt_valid_i: result for transfer in cycle t arrives at t+1+LATENCY.
REQ-022 res_valid[k] shall be 1 iff cvt_valid_i=1, tail tag valid=1 and tail tag id=k; combinational, no added latency.
REQ-023 res shall equal cvt_r combinationally in every cycle.
REQ-024 cvt_valid_i differing from tail tag valid shall set err on the next edge; res_valid stays 0 for that cycle; err cleared only by sys_rst.
REQ-025 idle shall be 1 iff req_ack=0, cvt_valid=0 and no tag stage valid.
REQ-026 drain asserted mid-operation: in-flight operations complete and deliver res_valid normally; idle rises the cycle after last tag leaves tail.
REQ-027 Simultaneous drain rise and req_valid: drain wins, no grant that cycle.
REQ-028 Requester dropping req_valid without ack: no transfer, ptr unchanged.

Reset
REQ-029 On sys_rst: req_ack=0, cvt_valid=0, cvt_a=0, all tags invalid, res_valid=0, err=0, ptr=3 (port 0 first priority), idle=1 while drain/req_valid permit.
REQ-030 Reset mid-operation discards in-flight tags; converter results returning after reset release set err.

Verification
REQ-031 Reset, LATENCY=2, req_valid=0001, req_a[31:0]=0x00000005 one cycle -> req_ack=0001 same cycle, cvt_valid=1/cvt_a=5 next cycle, res_valid=0001 three cycles after transfer when cvt_valid_i driven.
REQ-032 req_valid=1111 held 8 cycles -> grants 0001,0010,0100,1000,0001,... one per cycle; res_valid follows same order LATENCY+1 cycles later.
REQ-033 req_valid=1010 held after port 1 granted -> next grant 1000 then 0010, ports 0/2 never acked.
REQ-034 drain=1 with 2 operations in flight and req_valid=1111 -> req_ack=0000, both res_valid pulses delivered, idle=1 one cycle after last.
REQ-035 cvt_valid_i=1 with no tag in flight -> res_valid=0000, err=1 next cycle and held until sys_rst.

Source files
------------

// File: rtl/pfpu_cvt_arb_if.sv
// Bus bundle between four conversion requesters, the arbiter and the
// shared int-to-float converter. The arbiter takes the slave view.
interface pfpu_cvt_arb_if;
  logic [3:0]   req_valid;
  logic [127:0] req_a;
  logic [3:0]   req_ack;
  logic [31:0]  cvt_a;
  logic         cvt_valid;
  logic [31:0]  cvt_r;
  logic         cvt_valid_i;
  logic [31:0]  res;
  logic [3:0]   res_valid;
  logic         drain;
  logic         idle;
  logic         err;

  modport slave (
    input  req_valid, req_a, cvt_r, cvt_valid_i, drain,
    output req_ack, cvt_a, cvt_valid, res, res_valid, idle, err
  );

  modport master (
    output req_valid, req_a, cvt_r, cvt_valid_i, drain,
    input  req_ack, cvt_a, cvt_valid, res, res_valid, idle, err
  );
endinterface

// File: rtl/pfpu_cvt_arb.sv
// Round-robin arbiter sharing one pipelined int-to-float converter among
// four requesters. A tag pipeline matching the converter latency records
// which requester owns each result so it can be steered back on return.
module pfpu_cvt_arb #(
  parameter int LATENCY = 2
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  pfpu_cvt_arb_if.slave  bus
);

  logic [1:0]               ptr_q, ptr_d;
  logic [3:0]               ack;
  logic [1:0]               win;
  logic [1:0]               idx;
  logic                     xfer;
  logic signed [31:0]       op;

  logic                     cvt_valid_q, cvt_valid_d;
  logic signed [31:0]       cvt_a_q, cvt_a_d;
  logic [1:0]               cvt_id_q, cvt_id_d;

  logic [LATENCY-1:0]       tag_vld_q, tag_vld_d;
  logic [LATENCY-1:0][1:0]  tag_id_q, tag_id_d;
  logic                     tail_vld;
  logic [1:0]               tail_id;

  logic                     err_q, err_d;
  logic [3:0]               res_valid;

  // Round-robin search starting one past the last winner; drain blocks all grants
  always_comb begin
    ack  = '0;
    win  = ptr_q;
    xfer = 1'b0;
    idx  = '0;
    if (!bus.drain) begin
      for (int i = 1; i <= 4; i++) begin
        idx = ptr_q + 2'(i);
        if (!xfer && bus.req_valid[idx]) begin
          xfer     = 1'b1;
          win      = idx;
          ack[idx] = 1'b1;
        end
      end
    end
    ptr_d = xfer ? win : ptr_q;
  end

  // Issue stage: capture the winner's operand; operand holds when nothing issues
  always_comb begin
    op          = bus.req_a[{win, 5'd0} +: 32];
    cvt_valid_d = xfer;
    cvt_a_d     = xfer ? op : cvt_a_q;
    cvt_id_d    = win;
  end

  // Tag pipeline fed from the issue stage, shifting every cycle
  always_comb begin
    tag_vld_d    = tag_vld_q;
    tag_id_d     = tag_id_q;
    tag_vld_d[0] = cvt_valid_q;
    tag_id_d[0]  = cvt_id_q;
    for (int i = 1; i < LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
  end

  // Result steering and sticky error when converter strobe disagrees with tail tag
  always_comb begin
    tail_vld  = tag_vld_q[LATENCY-1];
    tail_id   = tag_id_q[LATENCY-1];
    res_valid = '0;
    if (bus.cvt_valid_i && tail_vld)
      res_valid = 4'b0001 << tail_id;
    err_d = err_q | (bus.cvt_valid_i ^ tail_vld);
  end

  // Control state, cleared asynchronously
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ptr_q       <= 2'd3;
      cvt_valid_q <= 1'b0;
      cvt_a_q     <= '0;
      tag_vld_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      cvt_valid_q <= cvt_valid_d;
      cvt_a_q     <= cvt_a_d;
      tag_vld_q   <= tag_vld_d;
      err_q       <= err_d;
    end
  end

  // Port ids only matter alongside a set valid bit, so they carry no reset
  always_ff @(posedge sys_clk) begin
    cvt_id_q <= cvt_id_d;
    tag_id_q <= tag_id_d;
  end

  assign bus.req_ack   = ack;
  assign bus.cvt_valid = cvt_valid_q;
  assign bus.cvt_a     = cvt_a_q;
  assign bus.res       = bus.cvt_r;
  assign bus.res_valid = res_valid;
  assign bus.err       = err_q;
  assign bus.idle      = (ack == 4'b0000) && !cvt_valid_q && !(|tag_vld_q);

endmodule

// File: tb/tb_pfpu_cvt_arb.sv
// Bench for pfpu_cvt_arb: a schedule-based model (which cycle each result is
// due, and for whom) checked every cycle, plus directed literal expectations.
module tb_pfpu_cvt_arb;
  localparam int L    = 2;
  localparam int NCYC = 4096;

  logic sys_clk;
  logic sys_rst;

  pfpu_cvt_arb_if bus();

  pfpu_cvt_arb #(.LATENCY(L)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model state
  int          ptr_m = 3;
  logic        cvv_m = 1'b0;
  logic [31:0] cva_m = '0;
  logic        err_m = 1'b0;
  bit          tag_v  [0:NCYC-1];
  int          tag_p  [0:NCYC-1];
  bit          conv_v [0:NCYC-1];
  logic [31:0] conv_r [0:NCYC-1];

  function automatic logic [31:0] fcvt(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h3f80_0000;
  endfunction

  // Grant rule: start one past the pointer, wrap, first requester wins
  function automatic logic [3:0] model_ack(input int p, input logic [3:0] rv, input logic dr);
    logic [3:0] g;
    bit found;
    g = '0;
    found = 0;
    if (!dr) begin
      for (int i = 1; i <= 4; i++) begin
        int k;
        k = (p + i) % 4;
        if (!found && rv[k]) begin
          g[k] = 1'b1;
          found = 1;
        end
      end
    end
    return g;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Model advance on each rising edge
  always @(posedge sys_clk) begin
    logic [3:0] a;
    if (sys_rst) begin
      ptr_m = 3;
      cvv_m = 1'b0;
      cva_m = '0;
      err_m = 1'b0;
      for (int j = 0; j < NCYC; j++) tag_v[j] = 0;
    end else begin
      a = model_ack(ptr_m, bus.req_valid, bus.drain);
      if (bus.cvt_valid_i != tag_v[cyc]) err_m = 1'b1;
      cvv_m = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (a[k]) begin
          ptr_m = k;
          cvv_m = 1'b1;
          cva_m = bus.req_a[32*k +: 32];
          tag_v[cyc+1+L]  = 1;
          tag_p[cyc+1+L]  = k;
          conv_v[cyc+1+L] = 1;
          conv_r[cyc+1+L] = fcvt(cva_m);
        end
      end
    end
    cyc++;
  end

  // Per-cycle comparison against the model, mid-cycle
  always @(negedge sys_clk) begin
    logic [3:0] e_ack, e_rv;
    bit busy;
    if (!sys_rst) begin
      e_ack = model_ack(ptr_m, bus.req_valid, bus.drain);
      e_rv  = (bus.cvt_valid_i && tag_v[cyc]) ? (4'b0001 << tag_p[cyc]) : 4'b0000;
      busy  = 0;
      for (int d = 0; d <= L; d++) if (tag_v[cyc+d]) busy = 1;
      chk("m_req_ack",   32'(bus.req_ack),   32'(e_ack));
      chk("m_cvt_valid", 32'(bus.cvt_valid), 32'(cvv_m));
      chk("m_cvt_a",     bus.cvt_a,          cva_m);
      chk("m_res_valid", 32'(bus.res_valid), 32'(e_rv));
      chk("m_res",       bus.res,            bus.cvt_r);
      chk("m_err",       32'(bus.err),       32'(err_m));
      chk("m_idle",      32'(bus.idle),      32'((e_ack == 4'b0000) && !cvv_m && !busy));
    end
  end

  // Advance one cycle and drive the converter's return strobe from its schedule
  task automatic tick();
    @(posedge sys_clk);
    #1;
    bus.cvt_valid_i = conv_v[cyc];
    bus.cvt_r       = conv_v[cyc] ? conv_r[cyc] : $urandom;
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    bus.drain     = 1'b0;
    repeat (4) tick();
    sys_rst = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] g8 [0:7];
    logic [3:0] g3 [0:3];
    g8 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    g3 = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};

    sys_rst         = 1'b0;
    bus.req_valid   = '0;
    bus.req_a       = '0;
    bus.drain       = 1'b0;
    bus.cvt_valid_i = 1'b0;
    bus.cvt_r       = '0;
    #1 sys_rst = 1'b1;
    tick();
    tick();
    #1;
    chk("rst_req_ack",   32'(bus.req_ack),   32'h0);
    chk("rst_cvt_valid", 32'(bus.cvt_valid), 32'h0);
    chk("rst_cvt_a",     bus.cvt_a,          32'h0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'h0);
    chk("rst_err",       32'(bus.err),       32'h0);
    chk("rst_idle",      32'(bus.idle),      32'h1);
    sys_rst = 1'b0;

    // Single transfer from port 0
    tick();
    bus.req_valid = 4'b0001;
    bus.req_a     = 128'h5;
    #1 chk("t1_ack", 32'(bus.req_ack), 32'h1);
    tick();
    bus.req_valid = 4'b0000;
    #1;
    chk("t1_cvt_valid", 32'(bus.cvt_valid), 32'h1);
    chk("t1_cvt_a",     bus.cvt_a,          32'h5);
    tick();
    tick();
    #1;
    chk("t1_res_valid", 32'(bus.res_valid), 32'h1);
    chk("t1_res",       bus.res,            32'h3f85_0000);
    tick();
    tick();
    #1 chk("t1_idle", 32'(bus.idle), 32'h1);

    // All four requesting: strict rotation, results in the same order
    do_reset();
    bus.req_a = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
    for (int i = 0; i < 11; i++) begin
      tick();
      bus.req_valid = (i < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (i < 8)  chk("rr_ack", 32'(bus.req_ack), 32'(g8[i]));
      if (i >= 3) chk("rr_res_valid", 32'(bus.res_valid), 32'(g8[i-3]));
    end

    // Ports 1 and 3 alternate after port 1 wins
    do_reset();
    tick();
    bus.req_valid = 4'b0010;
    #1 chk("alt_first", 32'(bus.req_ack), 32'h2);
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.req_valid = 4'b1010;
      #1 chk("alt_ack", 32'(bus.req_ack), 32'(g3[i]));
    end
    tick();
    bus.req_valid = 4'b0000;

    // Drain with two operations in flight
    do_reset();
    bus.req_a = {32'h0000_0d0d, 32'h0000_0c0c, 32'h0000_0b0b, 32'h0000_0a0a};
    tick();
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.req_valid = 4'b1111;
      bus.drain     = 1'b1;
      #1;
      chk("drain_ack", 32'(bus.req_ack), 32'h0);
      if (i == 1) chk("drain_res0", 32'(bus.res_valid), 32'h1);
      if (i == 2) chk("drain_res1", 32'(bus.res_valid), 32'h2);
      if (i == 2) chk("drain_busy", 32'(bus.idle), 32'h0);
      if (i == 3) chk("drain_idle", 32'(bus.idle), 32'h1);
    end
    tick();
    bus.drain = 1'b0;
    #1 chk("undrain_ack", 32'(bus.req_ack), 32'h4);
    tick();
    bus.req_valid = 4'b0000;

    // Spurious converter strobe: sticky error
    do_reset();
    tick();
    tick();
    bus.cvt_valid_i = 1'b1;
    #1;
    chk("spur_res_valid", 32'(bus.res_valid), 32'h0);
    chk("spur_err_pre",   32'(bus.err),       32'h0);
    tick();
    #1 chk("spur_err", 32'(bus.err), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.req_valid = (i == 1) ? 4'b0100 : 4'b0000;
      #1 chk("spur_err_hold", 32'(bus.err), 32'h1);
    end
    do_reset();
    #1 chk("spur_err_clr", 32'(bus.err), 32'h0);

    // Reset while a result is in flight: the late result flags an error
    tick();
    bus.req_valid = 4'b0001;
    bus.req_a     = 128'h77;
    tick();
    bus.req_valid = 4'b0000;
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    tick();
    #1 chk("late_res_valid", 32'(bus.res_valid), 32'h0);
    tick();
    #1 chk("late_err", 32'(bus.err), 32'h1);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
